flag_pc_ctrl: RTL and testbench
===============================

Name: flag_pc_ctrl

Overview:
- Execute-stage neighbour of the ALU. Consumes the ALU's 3-bit flag output and the current instruction's opcode.
- Owns the architectural flag register (Z, V, N) and the program counter.
- Resolves conditional B and BR, provides PC+2 for PCS, and latches HLT.
- Sits between the ALU and instruction fetch; its pc output drives the instruction-memory address.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 2, byte increment per sequential instruction

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
instr_valid  input  1  current instruction is valid; no state change when low
stall  input  1  hold PC and flags this cycle (upstream hazard)
opcode  input  4  current opcode, same encoding as ALU (ADD=0 … HLT=F)
ccc  input  3  branch condition code from instruction
imm9  input  9  signed word offset for B
br_target  input  16  register value for BR
alu_flags  input  3  ALU flags this cycle, {Z,V,N}
pc  output  16  registered program counter
pc_plus2  output  16  combinational pc + PC_STEP (PCS write data)
branch_taken  output  1  combinational, current B/BR taken
flags  output  3  registered {Z,V,N}
halted  output  1  registered, sticky halt indicator

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Reset values: pc=RESET_PC, flags=3'b000, halted=0. Reset overrides all other inputs, including in the halted state.

Update enable:
- upd = instr_valid & ~stall & ~halted.
- When upd=0, pc, flags and halted hold.

Flag register:
- Bit order is flags[2]=Z, flags[1]=V, flags[0]=N.
- ADD, SUB: load all three bits from alu_flags.
- XOR, SLL, SRA, ROR: load Z only; V and N hold.
- All other opcodes (RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT): flags hold.
- New flags are visible on flags the cycle after the setting instruction. There is no bypass.
- A branch in the cycle immediately after ADD sees the ADD's flags.

Condition evaluation (cond), using registered flags:
- 000 NEQ: ~Z
- 001 EQ: Z
- 010 GT: ~Z & ~N
- 011 LT: N
- 100 GTE: Z | (~Z & ~N)
- 101 LTE: N | Z
- 110 OVFL: V
- 111 UNCOND: 1

branch_taken:
- Equals cond & (opcode==B | opcode==BR) & instr_valid & ~halted.
- Not gated by stall.

Next PC when upd=1:
- B taken: pc_plus2 + ({{7{imm9[8]}}, imm9} << 1).
- BR taken: br_target. Bit 0 is passed through unaltered; alignment is not the job of this block.
- HLT: pc holds, halted←1.
- Otherwise: pc_plus2.
- All arithmetic is modulo 2^16. 16'hFFFE + 2 = 16'h0000. Negative offsets wrap.

Halt:
- halted is sticky until rst.
- Once halted, the block ignores instr_valid and stall.
- pc stays at the HLT instruction's address.

Stall:
- Both pc and flags hold.
- A stalled flag-setting instruction commits flags in the cycle it is finally issued with stall=0.

Latency:
- PC redirect takes effect one cycle after the branch is presented.
- There is no delay slot. Fetch and flush of the wrong-path instruction are owned upstream.

Test Plan:
- Reset, then instr_valid=1 with opcode=ADD for 3 cycles -> pc goes 0000, 0002, 0004, 0006. Assert rst mid-run -> pc=0000 and flags=000 on the next edge.
- ADD with alu_flags=3'b100, then B ccc=001 with imm9=9'h1FE (−2) at pc=0010 -> branch_taken=1, next pc=0012−4=000E. Same sequence with ccc=000 -> not taken, pc=0012.
- SUB with alu_flags=3'b011, then XOR with alu_flags=3'b100 -> flags=3'b111. Then PADDSB with alu_flags=3'b000 -> flags stays 3'b111. Then B with ccc=110 -> taken.
- pc=FFFE, opcode=LLB -> pc wraps to 0000. BR with ccc=111 and br_target=1234 -> pc=1234.
- HLT at pc=0040 -> halted=1 and pc stays 0040 under further valid ADDs. Next rst -> halted=0, pc=0000.
- stall=1 during ADD with alu_flags=3'b001 -> pc and flags unchanged. stall drops -> flags=3'b001 and pc advances by 2.

Source files
------------

// File: rtl/flag_pc_ctrl.sv
// Execute-stage flag register and program counter.
// Resolves B/BR conditions against the committed flags, provides PC+step, and latches HLT.
module flag_pc_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_STEP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic [3:0]  opcode,
  input  logic [2:0]  ccc,
  input  logic [8:0]  imm9,
  input  logic [15:0] br_target,
  input  logic [2:0]  alu_flags,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        branch_taken,
  output logic [2:0]  flags,
  output logic        halted
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [15:0] PC_STEP_W = 16'(PC_STEP);

  // flags are {Z,V,N}
  function automatic logic f_cond(input logic [2:0] cc, input logic [2:0] fl);
    logic z, v, n;
    z = fl[2];
    v = fl[1];
    n = fl[0];
    case (cc)
      3'b000:  f_cond = ~z;
      3'b001:  f_cond = z;
      3'b010:  f_cond = ~z & ~n;
      3'b011:  f_cond = n;
      3'b100:  f_cond = z | (~z & ~n);
      3'b101:  f_cond = n | z;
      3'b110:  f_cond = v;
      default: f_cond = 1'b1;
    endcase
  endfunction

  logic [15:0]        r_pc;
  logic [2:0]         r_flags;
  logic               r_halted;

  logic               w_upd;
  logic               w_cond;
  logic               w_is_b;
  logic               w_is_br;
  logic signed [15:0] w_off;
  logic [15:0]        w_pc_plus2;
  logic [15:0]        w_pc_nxt;
  logic [2:0]         w_flags_nxt;
  logic               w_halted_nxt;

  assign w_upd      = instr_valid & ~stall & ~r_halted;
  assign w_cond     = f_cond(ccc, r_flags);
  assign w_is_b     = (opcode == OP_B);
  assign w_is_br    = (opcode == OP_BR);
  assign w_off      = signed'({{6{imm9[8]}}, imm9, 1'b0});
  assign w_pc_plus2 = r_pc + PC_STEP_W;

  // Taken is reported even while stalled; the PC simply does not move yet.
  assign branch_taken = w_cond & (w_is_b | w_is_br) & instr_valid & ~r_halted;

  always_comb begin
    w_pc_nxt     = w_pc_plus2;
    w_flags_nxt  = r_flags;
    w_halted_nxt = r_halted;
    if (w_is_b && w_cond) begin
      w_pc_nxt = w_pc_plus2 + unsigned'(w_off);
    end else if (w_is_br && w_cond) begin
      w_pc_nxt = br_target;
    end else if (opcode == OP_HLT) begin
      w_pc_nxt     = r_pc;
      w_halted_nxt = 1'b1;
    end
    case (opcode)
      OP_ADD, OP_SUB:                 w_flags_nxt = alu_flags;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: w_flags_nxt = {alu_flags[2], r_flags[1:0]};
      default:                        w_flags_nxt = r_flags;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_flags  <= 3'b000;
      r_halted <= 1'b0;
    end else if (w_upd) begin
      r_pc     <= w_pc_nxt;
      r_flags  <= w_flags_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  assign pc       = r_pc;
  assign pc_plus2 = w_pc_plus2;
  assign flags    = r_flags;
  assign halted   = r_halted;

endmodule

// File: tb/tb_flag_pc_ctrl.sv
// Directed bench for flag_pc_ctrl with a reference model checked every cycle.
module tb_flag_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        stall;
  logic [3:0]  opcode;
  logic [2:0]  ccc;
  logic [8:0]  imm9;
  logic [15:0] br_target;
  logic [2:0]  alu_flags;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        branch_taken;
  logic [2:0]  flags;
  logic        halted;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // reference state
  int   m_pc;
  bit   m_z, m_v, m_n;
  bit   m_halted;

  flag_pc_ctrl #(.RESET_PC(16'h0000), .PC_STEP(2)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .stall(stall),
    .opcode(opcode), .ccc(ccc), .imm9(imm9), .br_target(br_target),
    .alu_flags(alu_flags), .pc(pc), .pc_plus2(pc_plus2),
    .branch_taken(branch_taken), .flags(flags), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_cond(input logic [2:0] c);
    case (int'(c))
      0: return !m_z;
      1: return m_z;
      2: return !m_z && !m_n;
      3: return m_n;
      4: return m_z || (!m_z && !m_n);
      5: return m_n || m_z;
      6: return m_v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit m_taken();
    return instr_valid && !m_halted && (opcode == 4'hC || opcode == 4'hD) && m_cond(ccc);
  endfunction

  // Model advance: what the architectural state must become after this edge.
  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_z = 0; m_v = 0; m_n = 0; m_halted = 0;
    end else if (instr_valid && !stall && !m_halted) begin
      int off;
      bit tk;
      off = int'($signed(imm9));
      tk  = m_cond(ccc);
      if (opcode == 4'hC && tk)      m_pc = (m_pc + 2 + off * 2) & 16'hFFFF;
      else if (opcode == 4'hD && tk) m_pc = int'(br_target);
      else if (opcode == 4'hF)       m_halted = 1;
      else                           m_pc = (m_pc + 2) & 16'hFFFF;
      if (opcode == 4'h0 || opcode == 4'h1) begin
        m_z = alu_flags[2]; m_v = alu_flags[1]; m_n = alu_flags[0];
      end else if (opcode == 4'h2 || opcode == 4'h4 || opcode == 4'h5 || opcode == 4'h6) begin
        m_z = alu_flags[2];
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc", pc, 16'(m_pc));
      chk("pc_plus2", pc_plus2, 16'((m_pc + 2) & 16'hFFFF));
      chk("flags", {13'd0, flags}, {13'd0, m_z, m_v, m_n});
      chk("halted", {15'd0, halted}, {15'd0, m_halted});
      chk("branch_taken", {15'd0, branch_taken}, {15'd0, m_taken()});
    end
  end

  task automatic drv(input logic v, input logic s, input logic [3:0] op, input logic [2:0] c,
                     input logic [8:0] im, input logic [15:0] tgt, input logic [2:0] af);
    instr_valid = v; stall = s; opcode = op; ccc = c; imm9 = im; br_target = tgt; alu_flags = af;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic s, input logic [3:0] op, input logic [2:0] c,
                      input logic [8:0] im, input logic [15:0] tgt, input logic [2:0] af);
    drv(v, s, op, c, im, tgt, af);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drv(1'b0, 1'b0, 4'h0, 3'b000, 9'h000, 16'h0000, 3'b000);
    tick();
    tick();
    cmp_en = 1'b1;
    chk("reset_pc", pc, 16'h0000);
    chk("reset_flags", {13'd0, flags}, 16'h0000);
    chk("reset_halted", {15'd0, halted}, 16'h0000);
    rst = 1'b0;

    // sequential ADDs, then reset mid-run
    step(1, 0, 4'h0, 3'b000, 9'h000, 16'h0000, 3'b101);
    chk("seq_pc1", pc, 16'h0002);
    step(1, 0, 4'h0, 3'b000, 9'h000, 16'h0000, 3'b101);
    chk("seq_pc2", pc, 16'h0004);
    step(1, 0, 4'h0, 3'b000, 9'h000, 16'h0000, 3'b101);
    chk("seq_pc3", pc, 16'h0006);
    chk("add_flags", {13'd0, flags}, 16'h0005);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_pc", pc, 16'h0000);
    chk("midrst_flags", {13'd0, flags}, 16'h0000);

    // walk to 000E with LW (flags hold), ADD Z=1, then EQ branch backwards
    for (int i = 0; i < 7; i++) step(1, 0, 4'h8, 3'b000, 9'h000, 16'h0000, 3'b111);
    chk("lw_pc", pc, 16'h000E);
    chk("lw_flags", {13'd0, flags}, 16'h0000);
    step(1, 0, 4'h0, 3'b000, 9'h000, 16'h0000, 3'b100);
    chk("pre_b_pc", pc, 16'h0010);
    drv(1, 0, 4'hC, 3'b001, 9'h1FE, 16'h0000, 3'b000);
    #2;
    chk("b_eq_taken", {15'd0, branch_taken}, 16'h0001);
    tick();
    chk("b_eq_pc", pc, 16'h000E);
    step(1, 0, 4'h0, 3'b000, 9'h000, 16'h0000, 3'b100);
    drv(1, 0, 4'hC, 3'b000, 9'h1FE, 16'h0000, 3'b000);
    #2;
    chk("b_neq_taken", {15'd0, branch_taken}, 16'h0000);
    tick();
    chk("b_neq_pc", pc, 16'h0012);

    // partial flag updates
    step(1, 0, 4'h1, 3'b000, 9'h000, 16'h0000, 3'b011);
    chk("sub_flags", {13'd0, flags}, 16'h0003);
    step(1, 0, 4'h2, 3'b000, 9'h000, 16'h0000, 3'b100);
    chk("xor_flags", {13'd0, flags}, 16'h0007);
    step(1, 0, 4'h7, 3'b000, 9'h000, 16'h0000, 3'b000);
    chk("paddsb_flags", {13'd0, flags}, 16'h0007);
    chk("paddsb_pc", pc, 16'h0018);
    drv(1, 0, 4'hC, 3'b110, 9'h004, 16'h0000, 3'b000);
    #2;
    chk("b_ovfl_taken", {15'd0, branch_taken}, 16'h0001);
    tick();
    chk("b_ovfl_pc", pc, 16'h0022);

    // wrap and BR
    step(1, 0, 4'hD, 3'b111, 9'h000, 16'hFFFE, 3'b000);
    chk("br_fffe", pc, 16'hFFFE);
    chk("pcs_wrap", pc_plus2, 16'h0000);
    step(1, 0, 4'hA, 3'b000, 9'h000, 16'h0000, 3'b000);
    chk("llb_wrap", pc, 16'h0000);
    step(1, 0, 4'hD, 3'b111, 9'h000, 16'h1234, 3'b000);
    chk("br_1234", pc, 16'h1234);
    step(1, 0, 4'hD, 3'b111, 9'h000, 16'h1235, 3'b000);
    chk("br_odd", pc, 16'h1235);

    // halt
    step(1, 0, 4'hD, 3'b111, 9'h000, 16'h0040, 3'b000);
    step(1, 0, 4'hF, 3'b000, 9'h000, 16'h0000, 3'b000);
    chk("hlt_halted", {15'd0, halted}, 16'h0001);
    chk("hlt_pc", pc, 16'h0040);
    step(1, 0, 4'h0, 3'b000, 9'h000, 16'h0000, 3'b001);
    step(1, 0, 4'h0, 3'b000, 9'h000, 16'h0000, 3'b001);
    chk("halt_hold_pc", pc, 16'h0040);
    chk("halt_hold_flags", {13'd0, flags}, 16'h0007);
    drv(1, 0, 4'hC, 3'b111, 9'h004, 16'h0000, 3'b000);
    #2;
    chk("halt_no_taken", {15'd0, branch_taken}, 16'h0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("unhalt", {15'd0, halted}, 16'h0000);
    chk("unhalt_pc", pc, 16'h0000);

    // stall and invalid
    step(1, 1, 4'h0, 3'b000, 9'h000, 16'h0000, 3'b001);
    chk("stall_pc", pc, 16'h0000);
    chk("stall_flags", {13'd0, flags}, 16'h0000);
    drv(1, 1, 4'hC, 3'b111, 9'h004, 16'h0000, 3'b000);
    #2;
    chk("stall_taken", {15'd0, branch_taken}, 16'h0001);
    tick();
    chk("stall_b_pc", pc, 16'h0000);
    step(1, 0, 4'h0, 3'b000, 9'h000, 16'h0000, 3'b001);
    chk("unstall_flags", {13'd0, flags}, 16'h0001);
    chk("unstall_pc", pc, 16'h0002);
    step(0, 0, 4'h0, 3'b000, 9'h000, 16'h0000, 3'b100);
    chk("invalid_pc", pc, 16'h0002);
    chk("invalid_flags", {13'd0, flags}, 16'h0001);
    step(1, 0, 4'hC, 3'b011, 9'h1FF, 16'h0000, 3'b000);
    chk("b_lt_pc", pc, 16'h0002);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
